// File: rtl/loopback_pkg.sv
// Shared constants, pointer types and operation encoding for the FX3 loopback buffer.
package loopback_pkg;

  localparam int unsigned LB_WIDTH = 32;
  localparam int unsigned LB_DEPTH = 1024;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int unsigned LB_AW = clog2(LB_DEPTH);

  // One extra MSB lets full and empty be told apart without a wrap flag.
  typedef logic [LB_AW:0] lb_ptr_t;
  typedef logic [LB_AW:0] lb_level_t;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_PUSH_POP,
    OP_FLUSH
  } lb_op_t;

endpackage

// File: rtl/loopback_fifo_ram.sv
// Simple dual-port storage for the loopback buffer: synchronous write and synchronous read.
module loopback_fifo_ram
  import loopback_pkg::*;
#(
  parameter int unsigned WIDTH = LB_WIDTH,
  parameter int unsigned DEPTH = LB_DEPTH
) (
  input  logic                      clk_100,
  input  logic                      wr_en,
  input  logic [clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]          rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_100) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/loopback_fifo.sv
// Show-ahead FIFO between the FX3 OUT and IN sockets, with registered status and sticky errors.
module loopback_fifo
  import loopback_pkg::*;
#(
  parameter int unsigned WIDTH    = LB_WIDTH,
  parameter int unsigned DEPTH    = LB_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic                    clk_100,
  input  logic                    reset_,
  input  logic [WIDTH-1:0]        din,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic [clog2(DEPTH):0]   level,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned AW = clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  ptr_t             wr_next;
  ptr_t             rd_next;
  ptr_t             level_next;
  lb_op_t           op;
  logic             push_ok;
  logic             pop_ok;
  logic             over_set;
  logic             under_set;
  logic             empty_next;
  logic             full_next;
  logic             bypass_next;
  logic             bypass;
  logic [WIDTH-1:0] bypass_data;
  logic [WIDTH-1:0] ram_data;

  always_comb begin
    op        = OP_IDLE;
    push_ok   = 1'b0;
    pop_ok    = 1'b0;
    over_set  = 1'b0;
    under_set = 1'b0;
    if (flush) begin
      op = OP_FLUSH;
    end else begin
      push_ok   = push && (!full || pop);
      pop_ok    = pop && !empty;
      over_set  = push && full && !pop;
      under_set = pop && empty;
      unique case ({push_ok, pop_ok})
        2'b10:   op = OP_PUSH;
        2'b01:   op = OP_POP;
        2'b11:   op = OP_PUSH_POP;
        default: op = OP_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_next = wr_ptr;
    rd_next = rd_ptr;
    unique case (op)
      OP_PUSH:     wr_next = wr_ptr + ptr_t'(1);
      OP_POP:      rd_next = rd_ptr + ptr_t'(1);
      OP_PUSH_POP: begin
        wr_next = wr_ptr + ptr_t'(1);
        rd_next = rd_ptr + ptr_t'(1);
      end
      OP_FLUSH: begin
        wr_next = '0;
        rd_next = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    level_next = wr_next - rd_next;
    empty_next = (wr_next == rd_next);
    full_next  = (wr_next[AW] != rd_next[AW]) &&
                 (wr_next[AW-1:0] == rd_next[AW-1:0]);
    // The RAM read port always fetches the next head; when that head is the word being
    // written this edge, the RAM would return stale data, so serve it from a bypass register.
    bypass_next = push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0]);
  end

  loopback_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_100 (clk_100),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (din),
    .rd_addr (rd_next[AW-1:0]),
    .rd_data (ram_data)
  );

  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      bypass       <= 1'b0;
      bypass_data  <= '0;
    end else begin
      wr_ptr       <= wr_next;
      rd_ptr       <= rd_next;
      level        <= level_next;
      empty        <= empty_next;
      full         <= full_next;
      almost_full  <= (32'(level_next) >= AF_LEVEL);
      almost_empty <= (32'(level_next) <= AE_LEVEL);
      bypass       <= bypass_next;
      if (bypass_next) begin
        bypass_data <= din;
      end
      if (flush) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        overflow  <= (overflow && !err_clr) || over_set;
        underflow <= (underflow && !err_clr) || under_set;
      end
    end
  end

  assign dout = empty ? '0 : (bypass ? bypass_data : ram_data);

endmodule

// File: tb/tb_loopback_fifo.sv
// Directed self-checking bench for loopback_fifo at default parameters (32 x 1024).
module tb_loopback_fifo;

  logic        clk_100;
  logic        reset_;
  logic [31:0] din;
  logic        push;
  logic        pop;
  logic        flush;
  logic        err_clr;
  logic [31:0] dout;
  logic        empty;
  logic        full;
  logic [10:0] level;
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        underflow;

  int checks;
  int errors;

  loopback_fifo dut (
    .clk_100      (clk_100),
    .reset_       (reset_),
    .din          (din),
    .push         (push),
    .pop          (pop),
    .flush        (flush),
    .err_clr      (err_clr),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dout"}, dout, 32'h0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_af"}, 32'(almost_full), 32'd0);
    chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_  = 1'b0;
    din     = '0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    err_clr = 1'b0;

    // Reset state
    #12;
    chk_reset_state("rst");
    reset_ = 1'b1;
    step();
    step();
    chk_reset_state("post_rst");

    // Single word into empty
    din = 32'hDEADBEEF; push = 1'b1;
    step();
    push = 1'b0;
    chk("one_empty", 32'(empty), 32'd0);
    chk("one_dout", dout, 32'hDEADBEEF);
    chk("one_level", 32'(level), 32'd1);
    chk("one_ae", 32'(almost_empty), 32'd1);
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("one_pop_empty", 32'(empty), 32'd1);
    chk("one_pop_level", 32'(level), 32'd0);
    chk("one_pop_dout", dout, 32'h0);

    // Fill 1..1024 with watermark tracking
    for (int i = 1; i <= 1024; i++) begin
      din = 32'(i); push = 1'b1;
      step();
      chk("fill_level", 32'(level), 32'(i));
      chk("fill_af", 32'(almost_full), (i >= 1020) ? 32'd1 : 32'd0);
      chk("fill_ae", 32'(almost_empty), (i <= 4) ? 32'd1 : 32'd0);
      chk("fill_dout", dout, 32'd1);
    end
    push = 1'b0;
    chk("fill_full", 32'(full), 32'd1);

    // Drain: one word per pop cycle
    for (int i = 1; i <= 1024; i++) begin
      chk("drain_dout", dout, 32'(i));
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_dout0", dout, 32'h0);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_ovf", 32'(overflow), 32'd0);
    chk("drain_unf", 32'(underflow), 32'd0);

    // Overflow: refill, push 0x55 into full
    for (int i = 1; i <= 1024; i++) begin
      din = 32'h1000 + 32'(i); push = 1'b1;
      step();
    end
    din = 32'h55;
    step();
    push = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd1024);
    step();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    // err_clr with a new overflow in the same cycle: set wins
    err_clr = 1'b1; push = 1'b1; din = 32'h55;
    step();
    push = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    step();
    err_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 1; i <= 1024; i++) begin
      chk("ovf_drain_dout", dout, 32'h1000 + 32'(i));
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    chk("ovf_drain_empty", 32'(empty), 32'd1);

    // Underflow
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_level", 32'(level), 32'd0);
    chk("unf_empty", 32'(empty), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("unf_cleared", 32'(underflow), 32'd0);

    // Simultaneous push+pop at level 1023
    for (int i = 1; i <= 1023; i++) begin
      din = 32'(i); push = 1'b1;
      step();
    end
    chk("sim_level0", 32'(level), 32'd1023);
    chk("sim_af0", 32'(almost_full), 32'd1);
    for (int k = 0; k < 3000; k++) begin
      chk("sim_dout", dout, 32'(k + 1));
      din = 32'(1024 + k); push = 1'b1; pop = 1'b1;
      step();
      chk("sim_level", 32'(level), 32'd1023);
      chk("sim_full", 32'(full), 32'd0);
    end
    push = 1'b0; pop = 1'b0;
    chk("sim_head_after", dout, 32'd3001);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sim_flush_empty", 32'(empty), 32'd1);

    // Simultaneous push+pop at level 0
    din = 32'hA0; push = 1'b1; pop = 1'b1;
    step();
    chk("sim0_unf", 32'(underflow), 32'd1);
    chk("sim0_level", 32'(level), 32'd1);
    chk("sim0_dout", dout, 32'hA0);
    for (int k = 1; k <= 20; k++) begin
      din = 32'hA0 + 32'(k);
      step();
      chk("sim0_run_level", 32'(level), 32'd1);
      chk("sim0_run_dout", dout, 32'hA0 + 32'(k));
    end
    push = 1'b0;
    step();
    pop = 1'b0;
    chk("sim0_final_empty", 32'(empty), 32'd1);

    // Flush at level 500 with a push in the same cycle; underflow is still set
    for (int i = 1; i <= 500; i++) begin
      din = 32'h2000 + 32'(i); push = 1'b1;
      step();
    end
    chk("fl_level", 32'(level), 32'd500);
    chk("fl_unf_before", 32'(underflow), 32'd1);
    din = 32'h77; flush = 1'b1;
    step();
    flush = 1'b0; push = 1'b0;
    chk("fl_level0", 32'(level), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_dout", dout, 32'h0);
    chk("fl_ovf", 32'(overflow), 32'd0);
    chk("fl_unf", 32'(underflow), 32'd0);
    din = 32'h88; push = 1'b1;
    step();
    push = 1'b0;
    chk("fl_next_dout", dout, 32'h88);
    chk("fl_next_level", 32'(level), 32'd1);

    // Async reset mid-burst at level 37
    for (int i = 2; i <= 37; i++) begin
      din = 32'h3000 + 32'(i); push = 1'b1;
      step();
    end
    chk("ar_level", 32'(level), 32'd37);
    chk("ar_dout", dout, 32'h88);
    #3;
    reset_ = 1'b0;
    #1;
    chk_reset_state("ar");
    push = 1'b0;
    step();
    #2;
    reset_ = 1'b1;
    step();
    din = 32'h99; push = 1'b1;
    step();
    push = 1'b0;
    chk("ar_after_dout", dout, 32'h99);
    chk("ar_after_level", 32'(level), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
